seq_mult_w: RTL

- Parametrised iterative shift-add multiplier for the ALU; successor to the fixed 16-bit signed multiply unit.
- Adds a per-operation signed/unsigned mode, a configurable operand width and a busy/done handshake.
- Produces registered result halves and mode-correct Z/N/C/V flags.
- Sits beside the ALU datapath; the control unit stalls on busy and samples results on done.

---
 rtl/seq_mult_w.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_mult_w.sv
// Iterative shift-add multiplier with signed/unsigned mode, busy/done handshake
// and registered product halves plus Z/N/C/V flags.
module seq_mult_w #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product_low,
    output logic [WIDTH-1:0] product_high,
    output logic             busy,
    output logic             done,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   r_sign;
    logic                   r_mode;
    logic [WIDTH-1:0]       r_mcand;
    logic [2*WIDTH:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;

    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [WIDTH:0]         w_addend;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_mag;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_hi;
    logic [WIDTH-1:0]       w_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == CNT_ONE) w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are reduced to magnitudes; the sign is reapplied once in FIX.
    assign w_abs_a  = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign w_addend = r_acc[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = r_acc[2*WIDTH:WIDTH] + w_addend;
    assign w_mag    = r_acc[2*WIDTH-1:0];
    assign w_prod   = r_sign ? -w_mag : w_mag;
    assign w_hi     = w_prod[2*WIDTH-1:WIDTH];
    assign w_lo     = w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign       <= 1'b0;
            r_mode       <= 1'b0;
            r_mcand      <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            product_low  <= '0;
            product_high <= '0;
            Z            <= 1'b0;
            N            <= 1'b0;
            C            <= 1'b0;
            V            <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode  <= signed_mode;
                r_sign  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_mcand <= w_abs_a;
                r_acc   <= {{(WIDTH+1){1'b0}}, w_abs_b};
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_CALC) begin
                // Multiplier bits shift out the bottom as the partial sum shifts in on top.
                r_acc <= {1'b0, w_sum, r_acc[WIDTH-1:1]};
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (r_state == S_FIX) begin
                product_high <= w_hi;
                product_low  <= w_lo;
                Z            <= (w_prod == '0);
                N            <= r_mode & w_hi[WIDTH-1];
                C            <= ~r_mode & (w_hi != '0);
                V            <= r_mode ? (w_hi != {WIDTH{w_lo[WIDTH-1]}}) : (w_hi != '0);
            end
        end
    end

endmodule
